adc_sample_scheduler: RTL and testbench
=======================================

Name: adc_sample_scheduler

Overview:
- Sequences periodic EMG/ECG acquisition from the ADC capture block into two circular sample buffers in the shared data RAM, through the RAM's dedicated ADC write port.
- Generates the sample tick, alternates channels and runs a request/acknowledge handshake with the ADC capture logic.
- Defers each RAM write while the CPU holds the port, and publishes write pointers and status so software and the VGA path can find the newest sample.

Parameters:
- SAMPLE_DIV, 175000, clock cycles between sample ticks (200 Hz at 35 MHz).
- EMG_BASE, 12'hC00, word address of EMG buffer entry 0.
- ECG_BASE, 12'h800, word address of ECG buffer entry 0.
- BUF_DEPTH, 640, entries per buffer; valid range 2..1023.
- ACK_TIMEOUT, 64, cycles to wait for adc_ack before abandoning a sample.
- HOLD_MAX, 16, cycles a write may be deferred by cpu_busy before it is dropped.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  acquisition enable; low freezes the tick counter
- adc_req  out  1  one-cycle request pulse to ADC capture
- adc_chan  out  1  channel of current request: 0=EMG, 1=ECG
- adc_ack  in  1  ADC data valid for current request
- adc_data  in  32  sample word, sampled when adc_ack=1
- cpu_busy  in  1  CPU drives a shared RAM cycle; ADC write must not issue
- ram_wen  out  1  ADC-port write enable, one cycle
- ram_addr  out  12  ADC-port write address
- ram_wdata  out  32  ADC-port write data
- emg_ptr  out  10  index of next EMG slot to be written
- ecg_ptr  out  10  index of next ECG slot to be written
- status  out  4  sticky flags {drop_hold, timeout, overrun, wrapped}
- clr_status  in  1  synchronous clear of all status bits

Behaviour:
- Reset: all outputs 0; state IDLE; tick counter 0; channel register 0 (EMG first). Reset mid-transaction abandons it; no write issues afterwards.
- Tick counter: counts 0..SAMPLE_DIV-1 while enable=1, holds while enable=0. Tick = one-cycle pulse when the counter wraps. First tick occurs SAMPLE_DIV cycles after reset release with enable high.
- States:
  - IDLE: on tick, adc_chan <= channel, adc_req=1 for exactly one cycle, go to WAIT.
  - WAIT: on adc_ack, latch adc_data, go to WRITE. If ACK_TIMEOUT cycles elapse without adc_ack, set status[2] (timeout), toggle channel, go to IDLE. adc_ack in IDLE is ignored.
  - WRITE: if cpu_busy=0, assert ram_wen for one cycle with ram_addr = base(chan) + ptr(chan) (12-bit, no overflow for legal parameters) and ram_wdata = latched data. Increment that channel's pointer, toggle channel, go to IDLE. If cpu_busy=1, hold with ram_wen=0. After HOLD_MAX consecutive busy cycles, set status[3] (drop_hold), toggle channel, go to IDLE with pointer unchanged.
- Latency: ack to ram_wen is 1 cycle when cpu_busy=0.
- Pointer wrap: a pointer equal to BUF_DEPTH-1 advances to 0 and sets status[0] (wrapped). Pointers change only in the cycle ram_wen=1 and are visible the following cycle.
- Overrun: a tick arriving in WAIT or WRITE sets status[1] and is discarded; no queueing; the channel is not toggled.
- The channel toggles exactly once per request on every exit path (write, timeout, drop), so EMG and ECG strictly alternate per request issued.
- Setting a status bit and clr_status in the same cycle: set wins.
- Only one ADC write is outstanding at any time. ram_wen is never asserted in a cycle with cpu_busy=1.

Test Plan:
- Reset, enable=1, SAMPLE_DIV=10, adc_ack 2 cycles after each req, cpu_busy=0. Required: adc_req at cycle 10 with chan 0; ram_wen at addr 0xC00; next req chan 1 writes 0x800; emg_ptr and ecg_ptr each 1.
- Hold cpu_busy=1 for 5 cycles in WRITE. Required: ram_wen asserts on the first cycle busy=0; data unchanged. Hold busy for 16 cycles instead: no write, status[3]=1, pointer unchanged.
- Never assert adc_ack. Required: after 64 cycles, status[2]=1; next tick requests chan 1; no ram_wen.
- BUF_DEPTH=4, run 8 EMG writes. Required: addresses 0xC00..0xC03, then 0xC00; emg_ptr returns to 0; status[0]=1.
- SAMPLE_DIV=3 with ack delay 5. Required: status[1]=1; intervening tick dropped; no duplicate req. Then pulse clr_status: status=0.
- Assert reset while in WAIT. Required: all outputs 0 immediately; a late adc_ack produces no write.

Source files
------------

// File: rtl/adc_sample_scheduler.sv
// Periodic two-channel ADC acquisition into circular RAM buffers through the
// dedicated ADC write port, with CPU-port deferral and sticky status flags.
module adc_sample_scheduler #(
    parameter int unsigned SAMPLE_DIV  = 175000,
    parameter logic [11:0] EMG_BASE    = 12'hC00,
    parameter logic [11:0] ECG_BASE    = 12'h800,
    parameter int unsigned BUF_DEPTH   = 640,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned HOLD_MAX    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic        adc_req,
    output logic        adc_chan,
    input  logic        adc_ack,
    input  logic [31:0] adc_data,
    input  logic        cpu_busy,
    output logic        ram_wen,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [9:0]  emg_ptr,
    output logic [9:0]  ecg_ptr,
    output logic [3:0]  status,
    input  logic        clr_status
);

    localparam int unsigned CNT_W  = (SAMPLE_DIV > 1)  ? $clog2(SAMPLE_DIV)  : 1;
    localparam int unsigned TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned HOLD_W = (HOLD_MAX > 1)    ? $clog2(HOLD_MAX)    : 1;
    localparam int unsigned PTR_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                chan_q, chan_d;
    logic                adc_chan_q, adc_chan_d;
    logic                adc_req_q, adc_req_d;
    logic [31:0]         data_q, data_d;
    logic [PTR_W-1:0]    emg_ptr_q, emg_ptr_d;
    logic [PTR_W-1:0]    ecg_ptr_q, ecg_ptr_d;
    logic [3:0]          status_q, status_d;

    logic                tick_c;
    logic                wen_c;
    logic [PTR_W-1:0]    cur_ptr_c;
    logic [PTR_W-1:0]    nxt_ptr_c;
    logic                ptr_last_c;

    assign tick_c     = enable && (count_q == CNT_W'(SAMPLE_DIV - 1));
    assign cur_ptr_c  = adc_chan_q ? ecg_ptr_q : emg_ptr_q;
    assign ptr_last_c = (cur_ptr_c == PTR_W'(BUF_DEPTH - 1));
    assign nxt_ptr_c  = ptr_last_c ? '0 : cur_ptr_c + PTR_W'(1);

    // Write strobe must track cpu_busy in the same cycle, so it is combinational.
    assign wen_c     = (state_q == WRITE) && !cpu_busy;
    assign ram_wen   = wen_c;
    assign ram_addr  = (state_q == WRITE) ? ((adc_chan_q ? ECG_BASE : EMG_BASE) + 12'(cur_ptr_c)) : '0;
    assign ram_wdata = (state_q == WRITE) ? data_q : '0;

    assign adc_req  = adc_req_q;
    assign adc_chan = adc_chan_q;
    assign emg_ptr  = emg_ptr_q;
    assign ecg_ptr  = ecg_ptr_q;
    assign status   = status_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            tmo_q      <= '0;
            hold_q     <= '0;
            chan_q     <= 1'b0;
            adc_chan_q <= 1'b0;
            adc_req_q  <= 1'b0;
            data_q     <= '0;
            emg_ptr_q  <= '0;
            ecg_ptr_q  <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            hold_q     <= hold_d;
            chan_q     <= chan_d;
            adc_chan_q <= adc_chan_d;
            adc_req_q  <= adc_req_d;
            data_q     <= data_d;
            emg_ptr_q  <= emg_ptr_d;
            ecg_ptr_q  <= ecg_ptr_d;
            status_q   <= status_d;
        end
    end

    // Next-state, datapath and sticky-flag logic; a flag set beats clr_status.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        hold_d     = hold_q;
        chan_d     = chan_q;
        adc_chan_d = adc_chan_q;
        adc_req_d  = 1'b0;
        data_d     = data_q;
        emg_ptr_d  = emg_ptr_q;
        ecg_ptr_d  = ecg_ptr_q;
        status_d   = clr_status ? 4'b0000 : status_q;

        if (!enable) begin
            count_d = count_q;
        end else if (tick_c) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    adc_chan_d = chan_q;
                    adc_req_d  = 1'b1;
                    tmo_d      = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (tick_c) begin
                    status_d[1] = 1'b1;
                end
                if (adc_ack) begin
                    data_d  = adc_data;
                    hold_d  = '0;
                    state_d = WRITE;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    status_d[2] = 1'b1;
                    chan_d      = ~chan_q;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WRITE: begin
                if (tick_c) begin
                    status_d[1] = 1'b1;
                end
                if (wen_c) begin
                    if (adc_chan_q) begin
                        ecg_ptr_d = nxt_ptr_c;
                    end else begin
                        emg_ptr_d = nxt_ptr_c;
                    end
                    if (ptr_last_c) begin
                        status_d[0] = 1'b1;
                    end
                    chan_d  = ~chan_q;
                    state_d = IDLE;
                end else if (hold_q == HOLD_W'(HOLD_MAX - 1)) begin
                    status_d[3] = 1'b1;
                    chan_d      = ~chan_q;
                    state_d     = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler: expected writes are queued when
// the ADC ack is driven and matched against the RAM port when ram_wen fires.
module tb_adc_sample_scheduler;

    localparam int unsigned DIV   = 10;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        adc_req;
    logic        adc_chan;
    logic        adc_ack = 1'b0;
    logic [31:0] adc_data = '0;
    logic        cpu_busy = 1'b0;
    logic        ram_wen;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [9:0]  emg_ptr;
    logic [9:0]  ecg_ptr;
    logic [3:0]  status;
    logic        clr_status = 1'b0;

    int  n_tests = 0;
    int  n_fail = 0;
    int  reqs_seen = 0;
    int  reqs_exp = 0;
    bit  chan_m = 1'b0;
    int  ptr_m [2] = '{0, 0};
    wr_t sb_q [$];
    wr_t mon_e;

    adc_sample_scheduler #(
        .SAMPLE_DIV (DIV),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .adc_req    (adc_req),
        .adc_chan   (adc_chan),
        .adc_ack    (adc_ack),
        .adc_data   (adc_data),
        .cpu_busy   (cpu_busy),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .emg_ptr    (emg_ptr),
        .ecg_ptr    (ecg_ptr),
        .status     (status),
        .clr_status (clr_status)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] base_of(input bit c);
        return c ? 12'h800 : 12'hC00;
    endfunction

    // Monitor: count requests, and match every RAM write against the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (adc_req) reqs_seen++;
            if (ram_wen) begin
                check("wen_while_busy", 32'(cpu_busy), 32'd0);
                if (sb_q.size() == 0) begin
                    check("spurious_wen", 32'(ram_wen), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
                    check("wr_data", ram_wdata, mon_e.data);
                end
            end
        end
    end

    task automatic outputs_zero(input string tag);
        check({tag, "_ctl"},   32'({adc_req, adc_chan, ram_wen, status}), 32'd0);
        check({tag, "_ptrs"},  32'({emg_ptr, ecg_ptr}), 32'd0);
        check({tag, "_addr"},  32'(ram_addr), 32'd0);
        check({tag, "_wdata"}, ram_wdata, 32'd0);
    endtask

    task automatic wait_req(output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clock);
            if (adc_req) begin
                n  = i;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'(adc_req), 32'd1);
        else     reqs_exp++;
    endtask

    // One request: ack after dly cycles, hold cpu_busy for busy WRITE cycles.
    task automatic txn(input int dly, input int busy, input bit drop, input bit clr, input int exp_wait);
        int          n;
        bit          ok;
        bit          hit;
        logic [31:0] d;
        wr_t         e;
        wait_req(n, ok);
        if (!ok) return;
        if (exp_wait > 0) check("req_latency", 32'(n), 32'(exp_wait));
        check("req_chan", 32'(adc_chan), 32'(chan_m));
        d = $urandom;
        for (int i = 1; i <= dly; i++) begin
            @(posedge clock);
            #1;
            clr_status = clr && (i == 1);
            if (clr && i == 2) check("status_clr", 32'(status), 32'd0);
        end
        adc_ack  = 1'b1;
        adc_data = d;
        cpu_busy = (busy > 0);
        if (!drop) begin
            e.addr = base_of(chan_m) + 12'(ptr_m[chan_m]);
            e.data = d;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        adc_ack  = 1'b0;
        adc_data = ~d;
        if (busy > 0) begin
            repeat (busy) @(posedge clock);
            #1;
            cpu_busy = 1'b0;
        end
        if (drop) begin
            @(negedge clock);
            check("drop_flag", 32'(status[3]), 32'd1);
            check("drop_emg_ptr", 32'(emg_ptr), 32'(ptr_m[0]));
            check("drop_ecg_ptr", 32'(ecg_ptr), 32'(ptr_m[1]));
        end else begin
            hit = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (ram_wen) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("wen_seen", 32'(hit), 32'd1);
            check("ptr_before", 32'(chan_m ? ecg_ptr : emg_ptr), 32'(ptr_m[chan_m]));
            ptr_m[chan_m] = (ptr_m[chan_m] + 1) % DEPTH;
            @(negedge clock);
            check("ptr_after", 32'(chan_m ? ecg_ptr : emg_ptr), 32'(ptr_m[chan_m]));
        end
        chan_m = ~chan_m;
    endtask

    task automatic timeout_case();
        int n;
        bit ok;
        wait_req(n, ok);
        if (!ok) return;
        check("tmo_req_chan", 32'(adc_chan), 32'(chan_m));
        repeat (63) @(negedge clock);
        check("tmo_early", 32'(status[2]), 32'd0);
        @(negedge clock);
        check("tmo_set", 32'(status[2]), 32'd1);
        chan_m = ~chan_m;
    endtask

    task automatic reset_in_wait();
        int n;
        bit ok;
        wait_req(n, ok);
        if (!ok) return;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        outputs_zero("rst_mid");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chan_m = 1'b0;
        ptr_m  = '{0, 0};
        @(posedge clock);
        #1;
        adc_ack  = 1'b1;
        adc_data = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        adc_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("late_ack_no_wen", 32'(ram_wen), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        outputs_zero("rst");
        reset = 1'b0;

        txn(2, 0, 1'b0, 1'b0, DIV);
        txn(2, 0, 1'b0, 1'b0, 0);
        check("emg_ptr_1", 32'(emg_ptr), 32'd1);
        check("ecg_ptr_1", 32'(ecg_ptr), 32'd1);

        txn(2, 5, 1'b0, 1'b0, 0);
        txn(2, 16, 1'b1, 1'b0, 0);

        timeout_case();
        txn(2, 0, 1'b0, 1'b1, 0);

        // Ack arrives after the next tick, which must be discarded as overrun.
        txn(12, 0, 1'b0, 1'b1, 0);
        check("overrun_flag", 32'(status[1]), 32'd1);
        check("req_count_mid", 32'(reqs_seen), 32'(reqs_exp));
        txn(2, 0, 1'b0, 1'b1, 0);

        for (int k = 0; k < 16; k++) begin
            txn(2, 0, 1'b0, (k == 0), 0);
        end
        check("wrap_status", 32'(status), 32'b0001);

        reset_in_wait();
        txn(2, 0, 1'b0, 1'b0, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("req_count", 32'(reqs_seen), 32'(reqs_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
